// File: rtl/dcache_refill.sv
// Data-cache miss engine: optional 4-beat victim writeback, then 4-beat line fetch into a 128-bit refill line.
// Latency: clean miss -> refill_valid 5 cycles after acceptance; dirty miss -> 9 cycles (mem_ready tied high).
// Backpressure: each mem_req cycle without mem_ready stalls the current beat, holding its address and data.
module dcache_refill #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_req,
  input  logic [ADDR_W-1:0] miss_addr,
  input  logic              wb_need,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [127:0]      wb_line,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output logic              refill_valid,
  output logic [127:0]      refill_line,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, WB, RD, DONE} state_t;

  state_t              state, nxt_state;
  logic [1:0]          cnt, nxt_cnt;
  logic [ADDR_W-5:0]   miss_la, nxt_miss_la;
  logic [ADDR_W-5:0]   wb_la, nxt_wb_la;
  logic [127:0]        wb_data, nxt_wb_data;
  logic                beat_done;
  logic [6:0]          nxt_bit;
  logic [6:0]          cur_bit;

  // mem_req is a register, so beat completion never depends combinationally on anything but mem_ready
  assign beat_done = mem_req && mem_ready;
  assign cur_bit   = {cnt, 5'd0};
  assign nxt_bit   = {nxt_cnt, 5'd0};

  // Next-state decode; captured request fields are exposed early so beat outputs can be registered
  always_comb begin
    nxt_state   = state;
    nxt_cnt     = cnt;
    nxt_miss_la = miss_la;
    nxt_wb_la   = wb_la;
    nxt_wb_data = wb_data;
    case (state)
      IDLE: begin
        if (miss_req) begin
          nxt_miss_la = miss_addr[ADDR_W-1:4];
          nxt_wb_la   = wb_addr[ADDR_W-1:4];
          nxt_wb_data = wb_line;
          nxt_cnt     = 2'd0;
          nxt_state   = wb_need ? WB : RD;
        end
      end
      WB: begin
        if (beat_done) begin
          nxt_cnt = cnt + 2'd1;
          if (cnt == 2'd3) nxt_state = RD;
        end
      end
      RD: begin
        if (beat_done) begin
          nxt_cnt = cnt + 2'd1;
          if (cnt == 2'd3) nxt_state = DONE;
        end
      end
      DONE: nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  // State, captured request and registered memory/refill outputs derived from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= 2'd0;
      miss_la      <= '0;
      wb_la        <= '0;
      wb_data      <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      refill_valid <= 1'b0;
      refill_line  <= '0;
      busy         <= 1'b0;
    end else begin
      state        <= nxt_state;
      cnt          <= nxt_cnt;
      miss_la      <= nxt_miss_la;
      wb_la        <= nxt_wb_la;
      wb_data      <= nxt_wb_data;
      mem_req      <= (nxt_state == WB) || (nxt_state == RD);
      mem_we       <= (nxt_state == WB);
      refill_valid <= (nxt_state == DONE);
      busy         <= (nxt_state != IDLE);
      if (nxt_state == WB) begin
        mem_addr  <= {nxt_wb_la, nxt_cnt, 2'b00};
        mem_wdata <= nxt_wb_data[nxt_bit +: 32];
      end else if (nxt_state == RD) begin
        mem_addr  <= {nxt_miss_la, nxt_cnt, 2'b00};
        mem_wdata <= '0;
      end else begin
        mem_addr  <= '0;
        mem_wdata <= '0;
      end
      if (state == RD && beat_done) refill_line[cur_bit +: 32] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dcache_refill.sv
module tb_dcache_refill;

  logic         clk = 1'b0;
  logic         rst;
  logic         miss_req;
  logic [31:0]  miss_addr;
  logic         wb_need;
  logic [31:0]  wb_addr;
  logic [127:0] wb_line;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic         mem_ready;
  logic [31:0]  mem_rdata;
  logic         refill_valid;
  logic [127:0] refill_line;
  logic         busy;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  dcache_refill #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .miss_req(miss_req), .miss_addr(miss_addr), .wb_need(wb_need),
    .wb_addr(wb_addr), .wb_line(wb_line),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .refill_valid(refill_valid), .refill_line(refill_line), .busy(busy)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks one beat cycle: request asserted with the given direction, address and (for writes) data
  task automatic chk_beat(input string tag, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    chk({tag, "_req"}, {127'd0, mem_req}, 128'd1);
    chk({tag, "_we"}, {127'd0, mem_we}, {127'd0, we});
    chk({tag, "_addr"}, {96'd0, mem_addr}, {96'd0, addr});
    if (we) chk({tag, "_wdata"}, {96'd0, mem_wdata}, {96'd0, wdata});
    chk({tag, "_busy"}, {127'd0, busy}, 128'd1);
    chk({tag, "_novalid"}, {127'd0, refill_valid}, 128'd0);
  endtask

  initial begin
    logic seen;
    rst = 1'b1; miss_req = 1'b0; miss_addr = '0; wb_need = 1'b0;
    wb_addr = '0; wb_line = '0; mem_ready = 1'b0; mem_rdata = '0;

    // Reset values
    @(negedge clk); @(negedge clk);
    chk("rst_req", {127'd0, mem_req}, 128'd0);
    chk("rst_we", {127'd0, mem_we}, 128'd0);
    chk("rst_addr", {96'd0, mem_addr}, 128'd0);
    chk("rst_wdata", {96'd0, mem_wdata}, 128'd0);
    chk("rst_valid", {127'd0, refill_valid}, 128'd0);
    chk("rst_line", refill_line, 128'd0);
    chk("rst_busy", {127'd0, busy}, 128'd0);
    rst = 1'b0;

    // Clean miss, mem_ready tied high: reads T+1..T+4, refill_valid at T+5
    @(negedge clk);
    miss_req = 1'b1; miss_addr = 32'h0000_1234; wb_need = 1'b0; mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk_beat("clean_rd", 1'b0, 32'h1230 + 32'(4 * k), 32'd0);
      mem_rdata = 32'hA0 + 32'(k);
    end
    @(negedge clk);
    chk("clean_valid", {127'd0, refill_valid}, 128'd1);
    chk("clean_line", refill_line, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    chk("clean_done_req", {127'd0, mem_req}, 128'd0);
    chk("clean_done_busy", {127'd0, busy}, 128'd1);
    miss_req = 1'b0;
    @(negedge clk);
    chk("clean_idle_valid", {127'd0, refill_valid}, 128'd0);
    chk("clean_idle_busy", {127'd0, busy}, 128'd0);
    chk("clean_line_hold", refill_line, {32'hA3, 32'hA2, 32'hA1, 32'hA0});

    // Dirty miss: writes T+1..T+4, reads T+5..T+8, refill_valid at T+9
    miss_req = 1'b1; miss_addr = 32'h0000_4000; wb_need = 1'b1;
    wb_addr = 32'h0000_8000; wb_line = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk_beat("dirty_wr", 1'b1, 32'h8000 + 32'(4 * k), 32'hD0 + 32'(k));
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk_beat("dirty_rd", 1'b0, 32'h4000 + 32'(4 * k), 32'd0);
      mem_rdata = 32'hB0 + 32'(k);
    end
    @(negedge clk);
    chk("dirty_valid", {127'd0, refill_valid}, 128'd1);
    chk("dirty_line", refill_line, {32'hB3, 32'hB2, 32'hB1, 32'hB0});
    miss_req = 1'b0; wb_need = 1'b0;
    @(negedge clk);
    chk("dirty_idle_busy", {127'd0, busy}, 128'd0);

    // Stalls: 3 low cycles per beat, each beat takes 4 cycles, refill_valid at T+17
    miss_req = 1'b1; miss_addr = 32'h0000_0770;
    for (int k = 0; k < 4; k++) begin
      for (int s = 0; s < 3; s++) begin
        @(negedge clk);
        mem_ready = 1'b0;
        chk_beat("stall_hold", 1'b0, 32'h0770 + 32'(4 * k), 32'd0);
      end
      @(negedge clk);
      chk_beat("stall_go", 1'b0, 32'h0770 + 32'(4 * k), 32'd0);
      mem_ready = 1'b1; mem_rdata = 32'h50 + 32'(k);
    end
    @(negedge clk);
    chk("stall_valid", {127'd0, refill_valid}, 128'd1);
    chk("stall_line", refill_line, {32'h53, 32'h52, 32'h51, 32'h50});
    miss_req = 1'b0;
    @(negedge clk);

    // Reset during the second read beat
    miss_req = 1'b1; miss_addr = 32'h0000_2000; mem_ready = 1'b1;
    @(negedge clk);
    chk_beat("mrst_rd0", 1'b0, 32'h2000, 32'd0);
    mem_rdata = 32'h11;
    @(negedge clk);
    chk_beat("mrst_rd1", 1'b0, 32'h2004, 32'd0);
    mem_rdata = 32'h22; rst = 1'b1; miss_req = 1'b0;
    @(negedge clk);
    chk("mrst_req", {127'd0, mem_req}, 128'd0);
    chk("mrst_busy", {127'd0, busy}, 128'd0);
    chk("mrst_line", refill_line, 128'd0);
    chk("mrst_addr", {96'd0, mem_addr}, 128'd0);
    rst = 1'b0;
    seen = refill_valid;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      seen = seen | refill_valid;
    end
    chk("mrst_no_valid", {127'd0, seen}, 128'd0);

    // Ignored requests while busy, then back-to-back miss right after refill_valid
    miss_req = 1'b1; miss_addr = 32'h0000_3000; wb_need = 1'b0;
    @(negedge clk);
    chk_beat("b2b_a_rd", 1'b0, 32'h3000, 32'd0);
    mem_rdata = 32'h70;
    @(negedge clk);
    chk_beat("b2b_a_rd", 1'b0, 32'h3004, 32'd0);
    mem_rdata = 32'h71; miss_req = 1'b0; miss_addr = 32'h0000_5000; wb_need = 1'b1;
    @(negedge clk);
    chk_beat("b2b_a_rd", 1'b0, 32'h3008, 32'd0);
    mem_rdata = 32'h72; miss_req = 1'b1;
    @(negedge clk);
    chk_beat("b2b_a_rd", 1'b0, 32'h300C, 32'd0);
    mem_rdata = 32'h73; wb_need = 1'b0;
    @(negedge clk);
    chk("b2b_a_valid", {127'd0, refill_valid}, 128'd1);
    chk("b2b_a_line", refill_line, {32'h73, 32'h72, 32'h71, 32'h70});
    miss_addr = 32'h0000_6000;
    @(negedge clk);
    chk("b2b_gap_req", {127'd0, mem_req}, 128'd0);
    chk("b2b_gap_busy", {127'd0, busy}, 128'd0);
    chk("b2b_gap_valid", {127'd0, refill_valid}, 128'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk_beat("b2b_b_rd", 1'b0, 32'h6000 + 32'(4 * k), 32'd0);
      mem_rdata = 32'hC0 + 32'(k);
    end
    @(negedge clk);
    chk("b2b_b_valid", {127'd0, refill_valid}, 128'd1);
    chk("b2b_b_line", refill_line, {32'hC3, 32'hC2, 32'hC1, 32'hC0});
    miss_req = 1'b0;
    @(negedge clk);
    chk("b2b_b_idle", {127'd0, busy}, 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/dcache_refill.md
# dcache_refill

Data-cache miss engine sitting directly upstream of the line write-merge stage. On a miss it optionally writes back the dirty 128-bit victim line as four 32-bit memory beats, then fetches the missing line as four 32-bit beats. It assembles those beats into a 128-bit line and presents that line, with a one-cycle valid pulse, as the cache-data input of the merge stage.

## Interface
Parameters:
- ADDR_W, 32, byte-address width; the line offset is addr[3:0], the word offset is addr[3:2].

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- miss_req  in  1  miss request; sampled only in IDLE.
- miss_addr  in  ADDR_W  missing line address; bits [3:0] ignored.
- wb_need  in  1  victim line dirty; sampled with miss_req.
- wb_addr  in  ADDR_W  victim line address; bits [3:0] ignored.
- wb_line  in  128  victim line data; word k = bits [32k+31:32k].
- mem_req  out  1  memory beat request, held until accepted.
- mem_we  out  1  1 = write beat, 0 = read beat.
- mem_addr  out  ADDR_W  beat address {line[ADDR_W-1:4], cnt, 2'b00}.
- mem_wdata  out  32  write-beat data, which is victim word cnt.
- mem_ready  in  1  beat completes in a cycle where mem_req && mem_ready are both 1; on a read beat mem_rdata is valid in that cycle.
- mem_rdata  in  32  read-beat data.
- refill_valid  out  1  one-cycle pulse when refill_line is complete.
- refill_line  out  128  assembled line; word k = bits [32k+31:32k]. This matches the merge stage's offset mapping, where offset 0 maps to [31:0].
- busy  out  1  state != IDLE.

## Operation
- The FSM has four states: IDLE, WB, RD, DONE. There is also a 2-bit beat counter cnt.
- **IDLE, miss_req=1 (acceptance):**
  - Capture miss_addr[ADDR_W-1:4], wb_need, wb_addr[ADDR_W-1:4] and wb_line into internal registers.
  - Set cnt=0.
  - Go to WB if wb_need=1, otherwise go to RD.
- **WB:**
  - mem_req=1, mem_we=1, address from the captured wb_addr, mem_wdata = captured word cnt.
  - On each completed beat, cnt increments.
  - Completion of beat cnt=3 moves the FSM to RD with cnt=0.
- **RD:**
  - mem_req=1, mem_we=0, address from the captured miss_addr.
  - On each completed beat, mem_rdata is written to refill_line word cnt and cnt increments.
  - Completion of beat cnt=3 moves the FSM to DONE.
- **DONE:**
  - refill_valid=1 for exactly this one cycle, mem_req=0.
  - Next state is IDLE.
- mem_ready while mem_req=0 is ignored.
- mem_req, mem_we, mem_addr and mem_wdata are functions of registered state only; there is no combinational path from any input to them.
- cnt wraps 3 -> 0 only on the WB->RD or RD->DONE transition. Beats are always issued in word order 0,1,2,3.
- refill_line holds its value after DONE and stays stable until a later RD beat overwrites a word. It is not cleared on acceptance.
- miss_req and all other request inputs are ignored outside IDLE. The requester holds miss_req until it sees refill_valid, and must drive miss_req=0 in the cycle after refill_valid unless it is issuing a new miss.
- When wb_need=0, wb_addr and wb_line are don't-care.

## Timing
- **Reset values:** state=IDLE, cnt=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, refill_valid=0, refill_line=0, busy=0.
- **Reset mid-operation:** rst high at any edge forces the reset values from the next cycle. The transfer is abandoned, no refill_valid is produced, and the partial refill_line is cleared.
- **Latency with mem_ready tied high** (miss_req accepted at edge T):
  - No writeback: read beats at cycles T+1..T+4, refill_valid at T+5.
  - Writeback: write beats at T+1..T+4, read beats at T+5..T+8, refill_valid at T+9.
- Each cycle with mem_req=1 and mem_ready=0 adds one cycle. mem_addr, mem_we and mem_wdata stay stable while mem_req=1 and the beat is not yet complete.
- The earliest next acceptance is the IDLE cycle immediately after DONE, so the minimum gap between refill_valid pulses is one cycle plus the full transfer.
- busy=1 from the cycle after acceptance through DONE inclusive.

## Test plan
- **Clean miss:** mem_ready=1, miss_req with miss_addr=0x0000_1234 and wb_need=0.
  - Required: read addresses 0x1230, 0x1234, 0x1238, 0x123C.
  - With rdata 0xA0, 0xA1, 0xA2, 0xA3, refill_line = {0xA3, 0xA2, 0xA1, 0xA0}.
  - refill_valid at T+5.
- **Dirty miss:** wb_need=1, wb_addr=0x8000, wb_line={0xD3, 0xD2, 0xD1, 0xD0}, miss_addr=0x4000.
  - Required: writes to 0x8000..0x800C with data 0xD0..0xD3, then reads from 0x4000..0x400C.
  - refill_valid at T+9.
- **Stalls:** mem_ready held low for 3 cycles on every beat.
  - Required: beat signals stable throughout each stall, each beat takes 4 cycles, refill_valid at T+17 for a clean miss.
- **Reset mid-transfer:** rst asserted during the second read beat.
  - Required: next cycle mem_req=0, busy=0, refill_line=0, and no refill_valid.
- **Back-to-back and ignored requests:** miss_req toggled with a different miss_addr while busy.
  - Required: ignored, and the original addresses complete.
  - A new miss issued in the cycle after refill_valid is accepted, and its first read beat appears the following cycle.
